// File: rtl/drp_responder_if.sv
// DRP bus between the reconfiguration sequencer (master) and the PLL DRP target (slave).
// DEN/DWE/DADDR/DI travel towards the target; DO/DRDY travel back.
interface drp_responder_if;
    logic        DEN;
    logic        DWE;
    logic [4:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;

    modport master (
        output DEN,
        output DWE,
        output DADDR,
        output DI,
        input  DO,
        input  DRDY
    );

    modport slave (
        input  DEN,
        input  DWE,
        input  DADDR,
        input  DI,
        output DO,
        output DRDY
    );
endinterface

// File: rtl/drp_responder.sv
// drp_responder: PLL DRP target model.
// 32 x 16-bit register file answered with a DRDY pulse LAT cycles after the DEN sample, plus a
// LOCKED model that relocks LOCK_CYC cycles after RST_PLL (or RSTX) is released.
// Optional build macro DRP_RESP_ERRCHK_EN: builds the sticky ERR protocol checker (DEN while
// busy, write while the PLL is out of reset). Without it ERR is tied low.
module drp_responder #(
    parameter int unsigned LAT      = 4,
    parameter int unsigned LOCK_CYC = 64,
    parameter int unsigned CBW      = 8
) (
    input  logic           CLK,
    input  logic           RSTX,
    drp_responder_if.slave drp,
    input  logic           RST_PLL,
    output logic           LOCKED,
    output logic           ERR
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [3:0]     LatLoad  = 4'(LAT - 1);
    localparam logic [CBW-1:0] LockLoad = CBW'(LOCK_CYC);

    state_e         state_q, state_d;
    logic [3:0]     lat_cnt_q, lat_cnt_d;
    logic           req_we_q, req_we_d;
    logic [4:0]     req_addr_q, req_addr_d;
    logic [15:0]    req_data_q, req_data_d;
    logic           drdy_q, drdy_d;
    logic [15:0]    do_q, do_d;
    logic           commit;
    logic           accept;
    logic [15:0]    regs_q [32];

    logic [CBW-1:0] lock_cnt_q, lock_cnt_d;
    logic           locked_q, locked_d;

    // The DRDY cycle still counts as busy, so a new request is taken no earlier than the cycle
    // after DRDY; that also guarantees a write has committed before a following read samples.
    assign accept = drp.DEN && (state_q == StIdle) && !drdy_q;

    // Transaction FSM: accept, count down the latency, then complete with a DRDY pulse.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        drdy_d     = 1'b0;
        do_d       = do_q;
        commit     = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    req_we_d   = drp.DWE;
                    req_addr_d = drp.DADDR;
                    req_data_d = drp.DI;
                    lat_cnt_d  = LatLoad;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (lat_cnt_q == 4'd0) begin
                    drdy_d  = 1'b1;
                    state_d = StIdle;
                    if (req_we_q) begin
                        commit = 1'b1;
                    end else begin
                        do_d = regs_q[req_addr_q];
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Transaction state and response registers.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q    <= StIdle;
            lat_cnt_q  <= 4'd0;
            req_we_q   <= 1'b0;
            req_addr_q <= 5'd0;
            req_data_q <= 16'h0000;
            drdy_q     <= 1'b0;
            do_q       <= 16'h0000;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            drdy_q     <= drdy_d;
            do_q       <= do_d;
        end
    end

    // Register file; a write lands in the same edge that raises DRDY.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (commit) begin
            regs_q[req_addr_q] <= req_data_q;
        end
    end

    // Lock model: RST_PLL reloads the counter; LOCKED rises on the edge the count reaches zero.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (RST_PLL) begin
            lock_cnt_d = LockLoad;
            locked_d   = 1'b0;
        end else if (lock_cnt_q != '0) begin
            lock_cnt_d = lock_cnt_q - CBW'(1);
            if (lock_cnt_q == CBW'(1)) begin
                locked_d = 1'b1;
            end
        end else begin
            locked_d = 1'b1;
        end
    end

    // Lock counter and LOCKED flag.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            lock_cnt_q <= LockLoad;
            locked_q   <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign drp.DO   = do_q;
    assign drp.DRDY = drdy_q;
    assign LOCKED   = locked_q;

`ifdef DRP_RESP_ERRCHK_EN
    logic busy_hit;
    logic err_q, err_d;

    assign busy_hit = drp.DEN && ((state_q == StBusy) || drdy_q);

    // Sticky checker: DEN while busy, or a write accepted with the PLL running.
    always_comb begin
        err_d = err_q;
        if (busy_hit || (accept && drp.DWE && !RST_PLL)) begin
            err_d = 1'b1;
        end
    end

    // ERR is only cleared by RSTX.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_drp_responder.sv
// Self-checking bench for drp_responder: directed scenarios plus a randomized read/write run
// against a register-array / cycle-age reference model.
module tb_drp_responder;

    localparam int LAT      = 4;
    localparam int LOCK_CYC = 64;
`ifdef DRP_RESP_ERRCHK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic CLK;
    logic RSTX;
    logic RST_PLL;
    logic LOCKED;
    logic ERR;

    drp_responder_if drp ();

    drp_responder #(
        .LAT      (LAT),
        .LOCK_CYC (LOCK_CYC),
        .CBW      (8)
    ) dut (
        .CLK     (CLK),
        .RSTX    (RSTX),
        .drp     (drp),
        .RST_PLL (RST_PLL),
        .LOCKED  (LOCKED),
        .ERR     (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mem [32];
    logic [15:0] exp_do;
    int          lock_age;   // edges since RST_PLL was last sampled high or RSTX released
    bit          err_flag;

    // One clock; inputs change and outputs are observed 1 ns after the edge.
    task automatic tick();
        logic rp;
        rp = RST_PLL;
        @(posedge CLK);
        #1;
        if (rp) lock_age = 0;
        else if (lock_age < LOCK_CYC) lock_age++;
    endtask

    task automatic do_rstx(input logic rst_pll);
        RSTX     = 1'b0;
        drp.DEN  = 1'b0;
        RST_PLL  = rst_pll;
        tick();
        tick();
        RSTX     = 1'b1;
        lock_age = 0;
        err_flag = 1'b0;
        exp_do   = 16'h0000;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    endtask

    // Issue one access and wait (bounded) for DRDY; updates the reference model.
    task automatic xfer(input logic we, input logic [4:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] dout, output logic [15:0] want,
                        output int early, output logic tail);
        logic [15:0] do_before;
        do_before = drp.DO;
        want = we ? exp_do : mem[a];
        if (we) mem[a] = d;
        else exp_do = mem[a];
        if (we && !RST_PLL) err_flag = 1'b1;
        drp.DEN = 1'b1; drp.DWE = we; drp.DADDR = a; drp.DI = d;
        tick();
        drp.DEN = 1'b0; drp.DWE = 1'($urandom); drp.DADDR = 5'($urandom);
        drp.DI = 16'($urandom);
        lat = -1; dout = 16'hxxxx; early = 0; tail = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (drp.DRDY) begin
                lat = i;
                dout = drp.DO;
                break;
            end
            if (drp.DO !== do_before) early++;
            tick();
        end
        if (lat >= 0) begin
            tick();
            tail = drp.DRDY;
        end
    endtask

    task automatic test_reset();
        RSTX = 1'b0; RST_PLL = 1'b0;
        drp.DEN = 1'b0; drp.DWE = 1'b0; drp.DADDR = 5'd0; drp.DI = 16'h0;
        #7;
        checks++;
        if (drp.DO !== 16'h0000 || drp.DRDY !== 1'b0 || LOCKED !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: DO=%h DRDY=%b LOCKED=%b ERR=%b, required 0000 0 0 0",
                     drp.DO, drp.DRDY, LOCKED, ERR);
        end
        do_rstx(1'b0);
        for (int n = 1; n <= 70; n++) begin
            tick();
            checks++;
            if (LOCKED !== (lock_age >= LOCK_CYC)) begin
                errors++;
                $display("FAIL reset_lock_cycle%0d: LOCKED=%b, required %b", n, LOCKED,
                         lock_age >= LOCK_CYC);
            end
        end
    endtask

    task automatic test_write_read();
        int lat, early; logic [15:0] dout, want; logic tail;
        RST_PLL = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL pll_reset_lock: LOCKED=%b, required 0", LOCKED);
        end
        xfer(1'b1, 5'd5, 16'hA5C3, lat, dout, want, early, tail);
        checks++;
        if (lat !== LAT || tail !== 1'b0 || dout !== want) begin
            errors++;
            $display("FAIL write5: lat=%0d tail=%b DO=%h, required lat=%0d tail=0 DO=%h",
                     lat, tail, dout, LAT, want);
        end
        xfer(1'b0, 5'd5, 16'h0000, lat, dout, want, early, tail);
        checks++;
        if (lat !== LAT || dout !== 16'hA5C3 || tail !== 1'b0) begin
            errors++;
            $display("FAIL read5: lat=%0d DO=%h tail=%b, required lat=%0d DO=a5c3 tail=0",
                     lat, dout, tail, LAT);
        end
        RST_PLL = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            tick();
            checks++;
            if (LOCKED !== (lock_age >= LOCK_CYC)) begin
                errors++;
                $display("FAIL relock_cycle%0d: LOCKED=%b, required %b", n, LOCKED,
                         lock_age >= LOCK_CYC);
            end
        end
        // A one-cycle RST_PLL pulse must force a full relock.
        RST_PLL = 1'b1;
        tick();
        RST_PLL = 1'b0;
        for (int n = 1; n <= 66; n++) begin
            tick();
            checks++;
            if (LOCKED !== (lock_age >= LOCK_CYC)) begin
                errors++;
                $display("FAIL pulse_relock_cycle%0d: LOCKED=%b, required %b", n, LOCKED,
                         lock_age >= LOCK_CYC);
            end
        end
    endtask

    task automatic test_read_unwritten();
        int lat, early; logic [15:0] dout, want; logic tail;
        RST_PLL = 1'b1;
        xfer(1'b0, 5'd31, 16'h0000, lat, dout, want, early, tail);
        checks++;
        if (lat !== LAT || dout !== 16'h0000) begin
            errors++;
            $display("FAIL read31: lat=%0d DO=%h, required lat=%0d DO=0000", lat, dout, LAT);
        end
        xfer(1'b0, 5'd5, 16'h0000, lat, dout, want, early, tail);
        checks++;
        if (lat !== LAT || dout !== 16'hA5C3 || early !== 0) begin
            errors++;
            $display("FAIL read5_hold: lat=%0d DO=%h early_changes=%0d, required %0d a5c3 0",
                     lat, dout, early, LAT);
        end
    endtask

    task automatic test_overlap();
        int first, count; logic [15:0] dout, want; int lat, early; logic tail;
        RST_PLL = 1'b1;
        drp.DEN = 1'b1; drp.DWE = 1'b0; drp.DADDR = 5'd5;
        exp_do = mem[5];
        tick();
        drp.DEN = 1'b0;
        tick();
        drp.DEN = 1'b1; drp.DWE = 1'b1; drp.DADDR = 5'd5; drp.DI = 16'h1234;
        err_flag = 1'b1;
        tick();
        drp.DEN = 1'b0; drp.DWE = 1'b0;
        first = -1; count = 0;
        for (int i = 2; i < 16; i++) begin
            if (drp.DRDY) begin
                count++;
                if (first < 0) first = i;
            end
            tick();
        end
        checks++;
        if (count !== 1 || first !== LAT) begin
            errors++;
            $display("FAIL overlap_drdy: count=%0d at=%0d, required count=1 at=%0d",
                     count, first, LAT);
        end
        checks++;
        if (ERR !== ChkEn) begin
            errors++;
            $display("FAIL overlap_err: ERR=%b, required %b", ERR, ChkEn);
        end
        xfer(1'b0, 5'd5, 16'h0000, lat, dout, want, early, tail);
        checks++;
        if (dout !== 16'hA5C3 || ERR !== ChkEn) begin
            errors++;
            $display("FAIL overlap_ignored: DO=%h ERR=%b, required a5c3 %b", dout, ERR, ChkEn);
        end
    endtask

    task automatic test_write_pll_running();
        int lat, early; logic [15:0] dout, want; logic tail; logic [15:0] d;
        do_rstx(1'b0);
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: ERR=%b, required 0", ERR);
        end
        d = 16'($urandom);
        xfer(1'b1, 5'd7, d, lat, dout, want, early, tail);
        checks++;
        if (lat !== LAT || ERR !== (ChkEn && err_flag)) begin
            errors++;
            $display("FAIL write7_running: lat=%0d ERR=%b, required %0d %b", lat, ERR, LAT,
                     ChkEn && err_flag);
        end
        xfer(1'b0, 5'd7, 16'h0000, lat, dout, want, early, tail);
        checks++;
        if (dout !== d) begin
            errors++;
            $display("FAIL read7: DO=%h, required %h", dout, d);
        end
    endtask

    task automatic test_abort();
        int lat, early, drdys; logic [15:0] dout, want; logic tail;
        RST_PLL = 1'b1;
        drp.DEN = 1'b1; drp.DWE = 1'b1; drp.DADDR = 5'd3; drp.DI = 16'hFFFF;
        tick();
        drp.DEN = 1'b0;
        tick();
        tick();
        do_rstx(1'b1);
        drdys = 0;
        for (int i = 0; i < 8; i++) begin
            if (drp.DRDY) drdys++;
            tick();
        end
        checks++;
        if (drdys !== 0) begin
            errors++;
            $display("FAIL abort_drdy: pulses=%0d, required 0", drdys);
        end
        xfer(1'b0, 5'd3, 16'h0000, lat, dout, want, early, tail);
        checks++;
        if (lat !== LAT || dout !== 16'h0000) begin
            errors++;
            $display("FAIL abort_read3: lat=%0d DO=%h, required %0d 0000", lat, dout, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int lat, early; logic [15:0] dout, want; logic tail;
        for (int k = 0; k < 4; k++) begin
            logic [4:0] a; logic [15:0] d;
            a = 5'($urandom);
            d = 16'($urandom);
            xfer(1'b1, a, d, lat, dout, want, early, tail);
            xfer(1'b0, a, 16'h0000, lat, dout, want, early, tail);
            checks++;
            if (dout !== d || lat !== LAT) begin
                errors++;
                $display("FAIL b2b_addr%0d: DO=%h lat=%0d, required %h %0d", a, dout, lat, d, LAT);
            end
        end
    endtask

    task automatic test_random();
        int lat, early; logic [15:0] dout, want; logic tail;
        for (int k = 0; k < 60; k++) begin
            logic we; logic [4:0] a; logic [15:0] d; int gap;
            we = 1'($urandom);
            a = 5'($urandom_range(0, 7));
            d = 16'($urandom);
            RST_PLL = ($urandom_range(0, 9) != 0);
            xfer(we, a, d, lat, dout, want, early, tail);
            checks++;
            if (lat !== LAT || dout !== want || tail !== 1'b0 || early !== 0) begin
                errors++;
                $display("FAIL rand%0d %s a=%0d: lat=%0d DO=%h tail=%b early=%0d, req %0d %h 0 0",
                         k, we ? "wr" : "rd", a, lat, dout, tail, early, LAT, want);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            checks++;
            if (LOCKED !== (lock_age >= LOCK_CYC) || ERR !== (ChkEn && err_flag)) begin
                errors++;
                $display("FAIL rand%0d_status: LOCKED=%b ERR=%b, required %b %b", k, LOCKED, ERR,
                         lock_age >= LOCK_CYC, ChkEn && err_flag);
            end
        end
    endtask

    initial begin
        lock_age = 0;
        err_flag = 1'b0;
        exp_do   = 16'h0000;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        test_reset();
        test_write_read();
        test_read_unwritten();
        test_overlap();
        test_write_pll_running();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drp_responder.md
Name: drp_responder

Overview:
- Synthesizable model of the PLL dynamic-reconfiguration-port (DRP) target, i.e. the responder end of the DRP bus driven by the PLL reconfiguration state machine.
- Holds a 32 x 16-bit register file, answers DEN/DWE strobes with a DRDY pulse after a fixed latency, and models LOCKED behaviour around RST_PLL.
- Used in place of the vendor PLL primitive in simulation, and as a stand-in for on-board bring-up of the reconfiguration sequencer.

Parameters:
- LAT, 4, cycles from DEN sample to DRDY pulse; legal range 1..15.
- LOCK_CYC, 64, cycles LOCKED stays low after RST_PLL deasserts (or after RSTX release).
- CBW, 8, lock counter width; must hold LOCK_CYC.

Ports:
- CLK  input  1  DRP clock; all logic on posedge.
- RSTX  input  1  asynchronous active-low reset.
- DEN  input  1  access strobe, one cycle per transaction.
- DWE  input  1  write enable, qualified by DEN.
- DADDR  input  5  register address, qualified by DEN.
- DI  input  16  write data, qualified by DEN & DWE.
- DO  output  16  read data, valid in DRDY cycle, held until next DRDY.
- DRDY  output  1  one-cycle completion pulse.
- RST_PLL  input  1  PLL reset, active high.
- LOCKED  output  1  modelled lock indicator.
- ERR  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (RSTX=0): DO=0, DRDY=0, LOCKED=0, ERR=0, all 32 registers=16'h0000, FSM=IDLE, lock counter loaded with LOCK_CYC.
- The FSM has two states, IDLE and BUSY.
- IDLE: when DEN=1, latch DWE/DADDR/DI, load the latency counter with LAT-1, and go to BUSY. If LAT=1, DRDY is asserted on the next edge.
- BUSY: decrement the counter. At count 0:
  - assert DRDY for one cycle;
  - if write, commit the latched DI to reg[DADDR];
  - if read, DO <= reg[DADDR];
  - return to IDLE.
- DRDY therefore rises exactly LAT cycles after the edge that sampled DEN.
- DO is unchanged on writes and held between reads.
- DEN while BUSY (including the DRDY cycle): the request is ignored and ERR is set. A new DEN is accepted no earlier than the cycle after DRDY.
- Back-to-back rule: write then read of the same address returns the written value, because the commit precedes the next accept.
- Lock model:
  - RST_PLL=1: LOCKED <= 0 on the next edge and the counter is reloaded with LOCK_CYC each cycle.
  - RST_PLL=0 with counter>0: decrement.
  - Counter reaches 0: LOCKED <= 1 and stays there until the next RST_PLL or RSTX.
  - After RSTX release with RST_PLL low, LOCKED rises LOCK_CYC cycles later.
- A short RST_PLL pulse (1 cycle) still forces a full LOCK_CYC relock.
- DRP accesses proceed normally regardless of RST_PLL or LOCKED.
- RSTX assertion mid-transaction aborts it: no DRDY and no register update.
- ERR is cleared only by RSTX.

Optional Feature:
- Macro: DRP_RESP_ERRCHK_EN.
- When defined:
  - ERR logic is present as described above.
  - ERR is additionally set by a write accepted while RST_PLL=0, since reconfiguration must happen with the PLL held in reset.
- When undefined: ERR is tied to 0, no checker logic is synthesized, and transactions behave identically otherwise.

Test Plan:
- Reset then idle with RST_PLL=0 -> LOCKED=0 for 64 cycles after RSTX release, 1 on cycle 64; DO=0, DRDY=0.
- RST_PLL=1 for 3 cycles; write 16'hA5C3 to addr 5; read addr 5 -> each DRDY occurs 4 cycles after DEN; read DO=16'hA5C3; LOCKED=0 during reset, 1 at 64 cycles after RST_PLL falls.
- Read an unwritten addr 31 -> DO=16'h0000. Then read addr 5 -> DO changes only in the DRDY cycle.
- Second DEN issued 2 cycles after the first -> it is ignored, only one DRDY occurs, and ERR=1 (checker built) and stays 1 until RSTX.
- Write addr 7 with RST_PLL=0 -> DRDY occurs and reg[7] is updated. With DRP_RESP_ERRCHK_EN, ERR=1; without it, ERR=0.
- Assert RSTX 2 cycles into a write of 16'hFFFF to addr 3, then read addr 3 -> no DRDY for the aborted write; read returns 16'h0000.
